// File: rtl/port_rr_arbiter.sv
// Round-robin arbiter draining N requester FIFO heads into a single
// one-word output register that a downstream consumer pops.
module port_rr_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned pckg_sz = 40
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           pndng_in,
  input  logic [N*pckg_sz-1:0]   data_in,
  output logic [N-1:0]           pop_out,
  output logic                   pndng,
  output logic [pckg_sz-1:0]     data_out,
  input  logic                   popin,
  output logic [$clog2(N)-1:0]   grant_id,
  output logic [15:0]            pkt_cnt
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [pckg_sz-1:0] data_q, data_d;
  logic [IW-1:0]      gid_q, gid_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               load_c;
  logic [IW-1:0]      grant_c;
  logic [pckg_sz-1:0] head_c;

  // First pending requester at or after ptr, wrapping modulo N.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] req,
                                            input logic [IW-1:0] ptr);
    int unsigned idx;
    rr_pick = '0;
    for (int unsigned k = N; k > 0; k--) begin
      idx = 32'(ptr) + (k - 1);
      if (idx >= N) idx = idx - N;
      if (req[idx]) rr_pick = IW'(idx);
    end
  endfunction

  assign grant_c = rr_pick(pndng_in, ptr_q);
  assign load_c  = ((state_q == EMPTY) || popin) && (|pndng_in);

  // Head word mux for the winning requester.
  always_comb begin
    head_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_c == IW'(i)) head_c = data_in[i*pckg_sz +: pckg_sz];
    end
  end

  // Next-state, counter and pop pulse.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pop_out = '0;

    case (state_q)
      EMPTY: begin
        if (load_c) state_d = FULL;
      end
      FULL: begin
        if (popin) begin
          cnt_d = cnt_q + CW'(1);
          if (!load_c) state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (load_c) begin
      data_d  = head_c;
      gid_d   = grant_c;
      ptr_d   = (grant_c == IW'(N - 1)) ? '0 : grant_c + IW'(1);
      pop_out = N'(1) << grant_c;
    end

    // A reset cycle must never drain a requester.
    if (reset) pop_out = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pndng    = (state_q == FULL);
  assign data_out = data_q;
  assign grant_id = gid_q;
  assign pkt_cnt  = cnt_q;

endmodule
